// File: rtl/vend_controller_if.sv
// Signal bundle between the vending controller and its peripherals:
// coin acceptor, front-panel buttons, dispenser motor and change hopper.
interface vend_controller_if #(
    parameter int CREDIT_W = 5
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                coin_ready;
    logic                coin_reject;
    logic                select;
    logic                cancel;
    logic                insufficient;
    logic                dispense_req;
    logic                dispense_ack;
    logic                vend_done;
    logic                fault;
    logic                change_req;
    logic                change_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    // Controller side.
    modport master (
        input  coin_valid, coin_type, select, cancel, dispense_ack, change_ack,
        output coin_ready, coin_reject, insufficient, dispense_req, vend_done,
               fault, change_req, credit, busy
    );

    // Peripheral / environment side.
    modport slave (
        output coin_valid, coin_type, select, cancel, dispense_ack, change_ack,
        input  coin_ready, coin_reject, insufficient, dispense_req, vend_done,
               fault, change_req, credit, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction controller: accumulates coin credit, sequences the
// dispenser, then pays change one nickel at a time. Handles cancel and timeout.
module vend_controller #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 5,
    parameter int TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    vend_controller_if.master      bus
);
    localparam int CREDIT_MAX = 2**CREDIT_W - 1;
    localparam int CNT_W      = $clog2(TIMEOUT);

    localparam logic [CREDIT_W-1:0] READY_LIMIT = CREDIT_W'(CREDIT_MAX - 5);
    localparam logic [CREDIT_W-1:0] PRICE_C     = CREDIT_W'(PRICE);
    localparam logic [CNT_W-1:0]    LAST_CNT    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [CNT_W-1:0]    cnt;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
        case (t)
            2'd0:    coin_value = CREDIT_W'(1);
            2'd1:    coin_value = CREDIT_W'(2);
            2'd2:    coin_value = CREDIT_W'(5);
            default: coin_value = '0;
        endcase
    endfunction

    // The ready limit guarantees even a quarter cannot overflow credit.
    assign bus.coin_ready = (state == COLLECT) && !bus.select && !bus.cancel &&
                            (credit_q <= READY_LIMIT);
    assign bus.credit     = credit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= COLLECT;
            credit_q         <= '0;
            cnt              <= '0;
            bus.coin_reject  <= 1'b0;
            bus.insufficient <= 1'b0;
            bus.vend_done    <= 1'b0;
            bus.fault        <= 1'b0;
            bus.dispense_req <= 1'b0;
            bus.change_req   <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every branch
            // reads the pre-edge values, independent of statement order.
            bus.coin_reject  <= 1'b0;
            bus.insufficient <= 1'b0;
            bus.vend_done    <= 1'b0;
            bus.fault        <= 1'b0;

            case (state)
                COLLECT: begin
                    if (bus.coin_valid && bus.coin_ready) begin
                        if (bus.coin_type == 2'd3)
                            bus.coin_reject <= 1'b1;
                        else
                            credit_q <= credit_q + coin_value(bus.coin_type);
                    end else if (bus.cancel) begin
                        if (credit_q != '0) begin
                            state          <= CHANGE;
                            bus.change_req <= 1'b1;
                            bus.busy       <= 1'b1;
                        end
                    end else if (bus.select) begin
                        if (credit_q >= PRICE_C) begin
                            state            <= VEND;
                            cnt              <= '0;
                            bus.dispense_req <= 1'b1;
                            bus.busy         <= 1'b1;
                        end else begin
                            bus.insufficient <= 1'b1;
                        end
                    end
                end

                VEND: begin
                    // An ack on the final counting cycle still wins over timeout.
                    if (bus.dispense_ack) begin
                        credit_q         <= credit_q - PRICE_C;
                        bus.vend_done    <= 1'b1;
                        bus.dispense_req <= 1'b0;
                        if (credit_q != PRICE_C) begin
                            state          <= CHANGE;
                            bus.change_req <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            bus.busy <= 1'b0;
                        end
                    end else if (cnt == LAST_CNT) begin
                        bus.fault        <= 1'b1;
                        bus.dispense_req <= 1'b0;
                        bus.change_req   <= 1'b1;
                        state            <= CHANGE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                CHANGE: begin
                    if (bus.change_ack) begin
                        credit_q <= credit_q - 1'b1;
                        if (credit_q == CREDIT_W'(1)) begin
                            state          <= COLLECT;
                            bus.change_req <= 1'b0;
                            bus.busy       <= 1'b0;
                        end
                    end
                end

                default: begin
                    state            <= COLLECT;
                    bus.dispense_req <= 1'b0;
                    bus.change_req   <= 1'b0;
                    bus.busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a behavioural model queues expected
// registered outputs per cycle; a negedge monitor pops and compares them.
module tb_vend_controller;
    localparam int PRICE      = 4;
    localparam int CREDIT_W   = 5;
    localparam int TIMEOUT    = 16;
    localparam int CREDIT_MAX = 2**CREDIT_W - 1;

    typedef struct packed {
        logic [15:0]         id;
        logic [CREDIT_W-1:0] credit;
        logic                busy;
        logic                dreq;
        logic                creq;
        logic                rej;
        logic                ins;
        logic                vd;
        logic                flt;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n_step = 0;
    exp_t sb[$];

    // Model state: 0 = collect, 1 = vend, 2 = change.
    int m_state  = 0;
    int m_credit = 0;
    int m_cnt    = 0;

    vend_controller_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_controller #(
        .PRICE   (PRICE),
        .CREDIT_W(CREDIT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("credit@%0d", e.id),       32'(bus.credit),       32'(e.credit));
            check($sformatf("busy@%0d", e.id),         32'(bus.busy),         32'(e.busy));
            check($sformatf("dispense_req@%0d", e.id), 32'(bus.dispense_req), 32'(e.dreq));
            check($sformatf("change_req@%0d", e.id),   32'(bus.change_req),   32'(e.creq));
            check($sformatf("coin_reject@%0d", e.id),  32'(bus.coin_reject),  32'(e.rej));
            check($sformatf("insufficient@%0d", e.id), 32'(bus.insufficient), 32'(e.ins));
            check($sformatf("vend_done@%0d", e.id),    32'(bus.vend_done),    32'(e.vd));
            check($sformatf("fault@%0d", e.id),        32'(bus.fault),        32'(e.flt));
        end
    end

    function automatic int coin_val(input logic [1:0] t);
        return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 5 : 0;
    endfunction

    // One clock cycle: drive inputs, check combinational coin_ready, advance
    // the model and queue what the registered outputs must show afterwards.
    task automatic step(input logic rst, input logic cv, input logic [1:0] ct,
                        input logic sel, input logic can,
                        input logic dack, input logic cack);
        logic ready;
        exp_t e;
        @(negedge clk);
        #2;
        reset            = rst;
        bus.coin_valid   = cv;
        bus.coin_type    = ct;
        bus.select       = sel;
        bus.cancel       = can;
        bus.dispense_ack = dack;
        bus.change_ack   = cack;
        #1;
        ready = (m_state == 0) && !sel && !can && (m_credit <= CREDIT_MAX - 5);
        if (!rst) check($sformatf("coin_ready@%0d", n_step), 32'(bus.coin_ready), 32'(ready));

        e = '0;
        if (rst) begin
            m_state = 0; m_credit = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            if (cv && ready) begin
                if (ct == 2'd3) e.rej = 1'b1;
                else m_credit += coin_val(ct);
            end else if (can) begin
                if (m_credit > 0) m_state = 2;
            end else if (sel) begin
                if (m_credit >= PRICE) begin m_state = 1; m_cnt = 0; end
                else e.ins = 1'b1;
            end
        end else if (m_state == 1) begin
            if (dack) begin
                m_credit -= PRICE;
                e.vd = 1'b1;
                m_state = (m_credit > 0) ? 2 : 0;
            end else if (m_cnt == TIMEOUT - 1) begin
                e.flt = 1'b1;
                m_state = 2;
            end else begin
                m_cnt++;
            end
        end else begin
            if (cack) begin
                m_credit -= 1;
                if (m_credit == 0) m_state = 0;
            end
        end

        e.id     = 16'(n_step);
        e.credit = CREDIT_W'(m_credit);
        e.busy   = (m_state != 0);
        e.dreq   = (m_state == 1);
        e.creq   = (m_state == 2);
        sb.push_back(e);
        n_step++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 2'd0, 0, 0, 0, 0);
    endtask

    task automatic coin(input logic [1:0] t);
        step(0, 1, t, 0, 0, 0, 0);
    endtask

    task automatic change_acks(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 2'd0, 0, 0, 0, 1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.coin_valid   = 1'b0;
        bus.coin_type    = 2'd0;
        bus.select       = 1'b0;
        bus.cancel       = 1'b0;
        bus.dispense_ack = 1'b0;
        bus.change_ack   = 1'b0;

        step(1, 0, 2'd0, 0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0, 0);

        // Exact-price vend: nickel, dime, nickel, select, ack on third VEND cycle.
        coin(2'd0); coin(2'd1); coin(2'd0);
        step(0, 0, 2'd0, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 2'd0, 0, 0, 1, 0);
        idle(1);

        // Quarter, vend, one nickel of change.
        coin(2'd2);
        step(0, 0, 2'd0, 1, 0, 0, 0);
        step(0, 0, 2'd0, 0, 0, 1, 0);
        idle(1);
        change_acks(1);
        idle(1);

        // Insufficient credit, cancel refund, slug rejection.
        coin(2'd1);
        step(0, 0, 2'd0, 1, 0, 0, 0);
        step(0, 0, 2'd0, 0, 1, 0, 0);
        change_acks(2);
        coin(2'd3);
        idle(1);

        // Dispenser timeout with credit 8: full refund path.
        coin(2'd2); coin(2'd1); coin(2'd0);
        step(0, 0, 2'd0, 1, 0, 0, 0);
        idle(TIMEOUT);
        change_acks(8);
        idle(1);

        // Rerun: ack on the final counting cycle is a success.
        coin(2'd2); coin(2'd1); coin(2'd0);
        step(0, 0, 2'd0, 1, 0, 0, 0);
        idle(TIMEOUT - 1);
        step(0, 0, 2'd0, 0, 0, 1, 0);
        change_acks(4);
        idle(1);

        // Credit 27: coin_ready blocked; select with a coin present.
        for (int i = 0; i < 5; i++) coin(2'd2);
        coin(2'd1);
        step(0, 1, 2'd0, 0, 0, 0, 0);
        step(0, 1, 2'd2, 1, 0, 0, 0);
        step(0, 0, 2'd0, 0, 0, 1, 0);
        change_acks(20);

        // Reset in CHANGE with credit 3 discards everything.
        step(1, 0, 2'd0, 0, 0, 0, 0);
        idle(2);

        @(negedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
